multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
Iterative multiply/divide sequencer for the 5-bit-opcode processor core. It runs on the R-type ALU path (opcode 00000) for ALU func 00110 (mul) and 00111 (div).
- The decode stage pulses ctrl_mult or ctrl_div.
- The block latches the operands and runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle.
- It asserts stall to freeze the pipeline while an operation is in flight, then pulses result_rdy to the writeback mux.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
ctrl_mult  in  1  one-cycle start pulse, signed multiply
ctrl_div  in  1  one-cycle start pulse, signed divide
operand_a  in  WIDTH  multiplicand / dividend, sampled on the start edge only
operand_b  in  WIDTH  multiplier / divisor, sampled on the start edge only
result  out  WIDTH  low WIDTH bits of product, or quotient
result_rdy  out  1  one-cycle pulse, result/exception valid
exception  out  1  overflow or divide-by-zero, valid with result_rdy
stall  out  1  high while an operation is in progress

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: state IDLE, counter 0, result 0, result_rdy 0, exception 0, stall 0.
- States and transitions:
  - IDLE: on ctrl_mult go to MUL; on ctrl_div go to DIV.
  - MUL / DIV: one iteration per cycle. The counter counts 0..WIDTH-1; at count WIDTH-1 go to DONE.
  - DONE: result_rdy=1 for exactly this cycle. Next state is IDLE, or MUL/DIV if a start pulse is present this cycle.
- Start edge: latch operand_a/operand_b, clear counter, record operation type and operand signs.
- Arithmetic: operands are converted to magnitudes at start. Unsigned iteration runs over the magnitudes, and the sign is fixed up in DONE (combinational negate into the result register on the DONE entry edge).
- Latency: start on edge 0 -> result_rdy high in the cycle after edge WIDTH+1, i.e. 33 cycles for WIDTH=32. Latency is fixed and never data-dependent, including error cases.
- stall = 1 in MUL and DIV, and combinationally in the start cycle (ctrl_* high). stall = 0 in IDLE without start, and in DONE without start.
- result and exception hold their values after DONE until the next DONE or reset. result_rdy never asserts outside DONE.
- Multiply: result = low WIDTH bits of the signed product. exception=1 if the full 2*WIDTH product is not representable as signed WIDTH bits.
- Divide:
  - Quotient truncates toward zero; the remainder is discarded.
  - operand_b=0: result=0, exception=1.
  - Most-negative / -1: result=0x80000000 (wrapped), exception=1.
- Simultaneous ctrl_mult and ctrl_div: treated as multiply.
- Start pulse while in MUL/DIV: aborts the current operation, relatches operands, restarts at counter 0. No result_rdy is produced for the aborted operation.
- reset asserted mid-operation: return to IDLE on that edge, no result_rdy; result and exception clear to 0.

Decomposition:
- Shared package holds:
  - opcode constant OP_RTYPE=5'b00000
  - ALU func constants FN_MUL=5'b00110 and FN_DIV=5'b00111
  - state encoding IDLE/MUL/DIV/DONE (2 bits)
  - WIDTH default
- One sub-module, multdiv_datapath. It contains the accumulator/product, remainder, quotient and operand registers plus the shift/add/subtract logic, and is steered by load/step/op/finish strobes.
- multdiv_seq keeps the FSM, counter, stall, result_rdy and exception decision.

Test Plan:
- ctrl_mult, a=6, b=-7 (0xFFFFFFF9) -> stall high for 33 cycles; result_rdy pulses once, 33 cycles after start; result=0xFFFFFFD6, exception=0.
- ctrl_div, a=100, b=-7 -> result=0xFFFFFFF2 (-14), exception=0; later ctrl_div a=-100, b=7 -> result=0xFFFFFFF2.
- ctrl_div, a=5, b=0 -> result_rdy after 33 cycles, result=0, exception=1; ctrl_div a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, exception=1.
- ctrl_mult, a=0x00010000, b=0x00010000 -> result=0x00000000, exception=1; a=0xFFFFFFFF, b=0xFFFFFFFF -> result=1, exception=0.
- ctrl_mult a=3, b=4, then ctrl_div a=20, b=4 at cycle 10 -> no result_rdy at cycle 33; a single result_rdy 33 cycles after the second start, result=5.
- Start multiply, assert reset at cycle 12 for 1 cycle -> state IDLE, stall=0, result=0, exception=0, and no result_rdy for 40 cycles.

Source files
------------

// File: rtl/multdiv_seq_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide sequencer.
package multdiv_seq_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] FN_MUL   = 5'b00110;
  localparam logic [4:0] FN_DIV   = 5'b00111;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Operand/accumulator registers with one-bit-per-step shift-add multiply and
// restoring divide over operand magnitudes, plus final sign fix-up.
module multdiv_datapath
  import multdiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] fin_val,
  output logic               b_zero
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic               bz_q, bz_d;

  logic [WIDTH-1:0]   mag_a, mag_b, rem_n;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff, divisor;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt, mag_fin;

  always_comb begin
    mag_a = a_in[WIDTH-1] ? ({WIDTH{1'b0}} - a_in) : a_in;
    mag_b = b_in[WIDTH-1] ? ({WIDTH{1'b0}} - b_in) : b_in;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide packs {remainder, dividend/quotient}; quotient bits shift in from the right.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divisor  = {1'b0, opnd_q};
    ge       = (rem_sh >= divisor);
    rem_diff = rem_sh - divisor;
    rem_n    = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_nxt  = {rem_n, acc_q[WIDTH-2:0], ge};

    step_nxt = op_div ? div_nxt : mul_nxt;
    mag_fin  = op_div ? {{WIDTH{1'b0}}, step_nxt[WIDTH-1:0]} : step_nxt;
    fin_val  = neg_q ? ({(2*WIDTH){1'b0}} - mag_fin) : mag_fin;

    if (load) begin
      acc_d  = op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      opnd_d = op_div ? mag_b : mag_a;
      neg_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
      bz_d   = (b_in == {WIDTH{1'b0}});
    end else if (step) begin
      acc_d  = step_nxt;
      opnd_d = opnd_q;
      neg_d  = neg_q;
      bz_d   = bz_q;
    end else begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      neg_d  = neg_q;
      bz_d   = bz_q;
    end

    if (finish) begin
      res_d = (op_div && bz_q) ? {WIDTH{1'b0}} : fin_val[WIDTH-1:0];
    end else begin
      res_d = res_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= {(2*WIDTH){1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      res_q  <= {WIDTH{1'b0}};
      neg_q  <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      bz_q   <= bz_d;
    end
  end

  assign result = res_q;
  assign b_zero = bz_q;

endmodule

// File: rtl/multdiv_seq.sv
// Multiply/divide sequencer: FSM, iteration counter, pipeline stall,
// result_rdy pulse and exception decision around multdiv_datapath.
module multdiv_seq
  import multdiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             result_rdy,
  output logic             exception,
  output logic             stall
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               exc_q, exc_d;

  logic               start_s, start_div_s;
  logic               load_s, step_s, finish_s, op_div_s;
  logic [2*WIDTH-1:0] fin_val_s;
  logic               b_zero_s, not_repr_s;

  assign start_s     = ctrl_mult | ctrl_div;
  assign start_div_s = ctrl_div & ~ctrl_mult;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b0;
    exc_d    = exc_q;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    op_div_s = (state_q == DIV);

    // Upper half must be pure sign extension of bit WIDTH-1 to fit in WIDTH signed bits.
    not_repr_s = (fin_val_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
                 (fin_val_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});

    if (start_s) begin
      state_d  = start_div_s ? DIV : MUL;
      cnt_d    = {CNT_W{1'b0}};
      load_s   = 1'b1;
      op_div_s = start_div_s;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        MUL, DIV: begin
          step_s = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            finish_s = 1'b1;
            state_d  = DONE;
            cnt_d    = {CNT_W{1'b0}};
            rdy_d    = 1'b1;
            exc_d    = ((state_q == DIV) && b_zero_s) || not_repr_s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdy_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      exc_q   <= exc_d;
    end
  end

  multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .step    (step_s),
    .finish  (finish_s),
    .op_div  (op_div_s),
    .a_in    (operand_a),
    .b_in    (operand_b),
    .result  (result),
    .fin_val (fin_val_s),
    .b_zero  (b_zero_s)
  );

  assign stall      = start_s | (state_q == MUL) | (state_q == DIV);
  assign result_rdy = rdy_q;
  assign exception  = exc_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed starts push expected results,
// a monitor pops and checks value, exception and latency on every result_rdy.
module tb_multdiv_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        result_rdy;
  logic        exception;
  logic        stall;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  multdiv_seq dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .result_rdy (result_rdy),
    .exception  (exception),
    .stall      (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Start one operation; optionally record the expected response 33 cycles later.
  task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] e_res, input logic e_exc);
    exp_t e;
    @(posedge clock); #1;
    ctrl_mult = ~is_div;
    ctrl_div  = is_div;
    operand_a = a;
    operand_b = b;
    if (push) begin
      e.res = e_res;
      e.exc = e_exc;
      e.cyc = cyc + 33;
      sb.push_back(e);
    end
    @(negedge clock);
    chk("stall_start", {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("sb_drain", sb.size(), 32'd0);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    exp_t e;
    cyc       = 0;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;

    fork
      forever begin
        @(negedge clock);
        if (result_rdy === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_rdy", {31'd0, result_rdy}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("exception", {31'd0, exception}, {31'd0, e.exc});
            chk("latency", cyc, e.cyc);
          end
        end
      end
    join_none

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_result", result, 32'd0);
    chk("rst_rdy", {31'd0, result_rdy}, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // 6 * -7 with stall profile and result hold afterwards
    issue(1'b0, 32'd6, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFD6, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      chk("stall_busy", {31'd0, stall}, 32'd1);
    end
    @(negedge clock);
    chk("stall_done", {31'd0, stall}, 32'd0);
    repeat (5) @(negedge clock);
    chk("hold_result", result, 32'hFFFF_FFD6);
    chk("hold_rdy", {31'd0, result_rdy}, 32'd0);
    wait_empty();

    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 1'b0);
    wait_empty();
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0);
    wait_empty();
    issue(1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1);
    wait_empty();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    wait_empty();
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1);
    wait_empty();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b0);
    wait_empty();
    issue(1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b0);
    wait_empty();

    // Abort: multiply at cycle N, divide at N+10; only the divide reports.
    issue(1'b0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0);
    repeat (8) @(posedge clock);
    issue(1'b1, 32'd20, 32'd4, 1'b1, 32'd5, 1'b0);
    wait_empty();

    // Leave nonzero result/exception, then reset mid-multiply at cycle N+12.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    wait_empty();
    issue(1'b0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
    repeat (10) @(posedge clock);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_exc", {31'd0, exception}, 32'd0);
    repeat (40) @(posedge clock);
    chk("midrst_quiet", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
